// File: rtl/approx_mult_pkg.sv
// Shared widths and the compensation-term function for the approximate multiplier.
package approx_mult_pkg;

   localparam int unsigned APPROX_N_DEF  = 8;
   localparam int unsigned APPROX_PROD_W = 2 * APPROX_N_DEF;
   localparam int unsigned APPROX_ERR_W  = APPROX_PROD_W + 1;
   localparam int unsigned APPROX_MAX_W  = 32;

   // Count of dropped-row bits landing at weight >= 2^n, plus one if any dropped bit sits at 2^(n-1).
   function automatic int unsigned approx_comp(input logic [APPROX_MAX_W-1:0] x_lo,
                                               input logic [APPROX_MAX_W-1:0] y,
                                               input int unsigned             n,
                                               input int unsigned             l);
      int unsigned sum;
      logic        any_hi;
      sum    = 0;
      any_hi = 1'b0;
      for (int unsigned i = 0; i < APPROX_MAX_W; i++) begin
         if (i < l) begin
            for (int unsigned j = 0; j < APPROX_MAX_W; j++) begin
               if (j < n) begin
                  if (i + j >= n) sum = sum + 32'(x_lo[i] & y[j]);
                  if (i + j == n - 1) any_hi = any_hi | (x_lo[i] & y[j]);
               end
            end
         end
      end
      return sum + 32'(any_hi);
   endfunction

endpackage

// File: rtl/approx_mult_comp.sv
// Combinational compensation generator for the truncated low rows of x.
module approx_mult_comp
   import approx_mult_pkg::*;
#(
   parameter int unsigned N = APPROX_N_DEF,
   parameter int unsigned L = 2
) (
   input  logic [N-1:0] x_i,
   input  logic [N-1:0] y_i,
   output logic [N-1:0] comp_o
);

   localparam logic [N-1:0] LO_MASK = {N{1'b1}} >> (N - L);

   always_comb begin
      comp_o = N'(approx_comp(APPROX_MAX_W'(x_i & LO_MASK), APPROX_MAX_W'(y_i), N, L));
   end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined N x N approximate/exact multiplier with valid/ready on both sides.
// Optional error monitor (err_last, err_acc, txn_cnt) enabled by APPROX_MULT_ERR_MON_EN.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int unsigned N         = APPROX_N_DEF,
   parameter int unsigned L         = 2,
   parameter int unsigned ERR_ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         x,
   input  logic [N-1:0]         y,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*N-1:0]       z
`ifdef APPROX_MULT_ERR_MON_EN
   ,
   output logic signed [2*N:0]  err_last,
   output logic [ERR_ACC_W-1:0] err_acc,
   output logic [ERR_ACC_W-1:0] txn_cnt
`endif
);

   localparam int unsigned  PROD_W  = 2 * N;
   localparam logic [N-1:0] LO_MASK = {N{1'b1}} >> (N - L);

   if (L >= N || ERR_ACC_W == 0) begin : g_bad_params
      $error("approx_mult_pipe: need L < N and ERR_ACC_W > 0");
   end

   logic              s1_valid_q, s1_valid_d;
   logic [PROD_W-1:0] kept_q, kept_d;
   logic [PROD_W-1:0] lo_q, lo_d;
   logic [N-1:0]      comp_q, comp_d;
   logic              mode_q, mode_d;
   logic              out_valid_q, out_valid_d;
   logic [PROD_W-1:0] z_q, z_d;

   logic              s2_adv_c, s1_adv_c, in_xfer_c;
   logic [N-1:0]      comp_c;
   logic [PROD_W-1:0] kept_sh_c, exact_c, approx_c, z_new_c;

   approx_mult_comp #(.N(N), .L(L)) u_comp (
      .x_i    (x),
      .y_i    (y),
      .comp_o (comp_c)
   );

   // Handshake plus both stage datapaths; stage 1 keeps the partial sums, stage 2 assembles z.
   always_comb begin
      s2_adv_c  = !out_valid_q || out_ready;
      s1_adv_c  = !s1_valid_q || s2_adv_c;
      in_xfer_c = in_valid && s1_adv_c;
      kept_sh_c = kept_q << L;
      exact_c   = kept_sh_c + lo_q;
      approx_c  = kept_sh_c + (PROD_W'(comp_q) << N);
      z_new_c   = mode_q ? approx_c : exact_c;

      s1_valid_d  = s1_valid_q;
      kept_d      = kept_q;
      lo_d        = lo_q;
      comp_d      = comp_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;

      if (s1_adv_c) s1_valid_d = in_valid;
      if (in_xfer_c) begin
         kept_d = PROD_W'(x >> L) * PROD_W'(y);
         lo_d   = PROD_W'(x & LO_MASK) * PROD_W'(y);
         comp_d = comp_c;
         mode_d = approx_en;
      end

      if (s2_adv_c) out_valid_d = s1_valid_q;
      if (s2_adv_c && s1_valid_q) z_d = z_new_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         kept_q      <= '0;
         lo_q        <= '0;
         comp_q      <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         kept_q      <= kept_d;
         lo_q        <= lo_d;
         comp_q      <= comp_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
      end
   end

   assign in_ready  = s1_adv_c;
   assign out_valid = out_valid_q;
   assign z         = z_q;

`ifdef APPROX_MULT_ERR_MON_EN
   localparam int unsigned ERR_W = PROD_W + 1;
   localparam int unsigned SUM_W = ((ERR_ACC_W > ERR_W) ? ERR_ACC_W : ERR_W) + 1;
   localparam logic [ERR_ACC_W-1:0] ACC_MAX = '1;

   logic signed [ERR_W-1:0] err_last_q, err_last_d;
   logic [ERR_ACC_W-1:0]    err_acc_q, err_acc_d;
   logic [ERR_ACC_W-1:0]    txn_cnt_q, txn_cnt_d;
   logic [ERR_W-1:0]        err_abs_c;
   logic [SUM_W-1:0]        acc_sum_c;

   // Error word travels with z; accumulator and count advance only on output transfers.
   always_comb begin
      err_last_d = err_last_q;
      err_acc_d  = err_acc_q;
      txn_cnt_d  = txn_cnt_q;
      err_abs_c  = err_last_q[ERR_W-1] ? ERR_W'(-err_last_q) : ERR_W'(err_last_q);
      acc_sum_c  = SUM_W'(err_acc_q) + SUM_W'(err_abs_c);

      if (s2_adv_c && s1_valid_q) err_last_d = ERR_W'(exact_c) - ERR_W'(z_new_c);
      if (out_valid_q && out_ready) begin
         err_acc_d = (acc_sum_c > SUM_W'(ACC_MAX)) ? ACC_MAX : ERR_ACC_W'(acc_sum_c);
         if (txn_cnt_q != ACC_MAX) txn_cnt_d = txn_cnt_q + ERR_ACC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_last_q <= '0;
         err_acc_q  <= '0;
         txn_cnt_q  <= '0;
      end else begin
         err_last_q <= err_last_d;
         err_acc_q  <= err_acc_d;
         txn_cnt_q  <= txn_cnt_d;
      end
   end

   assign err_last = err_last_q;
   assign err_acc  = err_acc_q;
   assign txn_cnt  = txn_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: main instance (N=8, L=2) plus L in {0,1,3,7} instances on shared stimulus.
module tb_approx_mult_pipe;
   import approx_mult_pkg::*;

   localparam int unsigned LS [4] = '{0, 1, 3, 7};

   typedef struct {
      logic [7:0]                     x;
      logic [7:0]                     y;
      logic                           m;
      logic                           uc;
      logic [APPROX_PROD_W-1:0]       cz;
      logic signed [APPROX_ERR_W-1:0] ce;
   } sb_t;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, approx_en, out_valid, out_ready;
   logic [7:0] x, y;
   logic [APPROX_PROD_W-1:0] z;
   logic r_in_ready [4];
   logic r_out_valid [4];
   logic [APPROX_PROD_W-1:0] r_z [4];
   logic [7:0] chk_x, chk_y, cmp_main;
   logic [7:0] cmp_r [4];

   logic cur_uc;
   logic [APPROX_PROD_W-1:0] cur_cz;
   logic signed [APPROX_ERR_W-1:0] cur_ce;

   sb_t sb [$];
   int unsigned n_chk = 0, n_pass = 0;
   int unsigned n_push = 0, n_pop = 0, n_flush = 0;
   int unsigned run = 0, run_done = 0;
   logic stall_prev = 1'b0;
   logic [APPROX_PROD_W-1:0] z_prev = '0;

`ifdef APPROX_MULT_ERR_MON_EN
   logic signed [APPROX_ERR_W-1:0] err_last;
   logic [31:0] err_acc, txn_cnt;
   logic signed [APPROX_ERR_W-1:0] r_err [4];
   logic [7:0] r_acc [4];
   logic [7:0] r_cnt [4];
   longint acc_m = 0, cnt_m = 0;
   longint acc_rm [4] = '{0, 0, 0, 0};
   longint cnt_rm [4] = '{0, 0, 0, 0};
`endif

   always #5 clk = ~clk;

   approx_mult_pipe #(.N(8), .L(2), .ERR_ACC_W(32)) u_dut (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
      .x (x), .y (y), .approx_en (approx_en),
      .out_valid (out_valid), .out_ready (out_ready), .z (z)
`ifdef APPROX_MULT_ERR_MON_EN
      , .err_last (err_last), .err_acc (err_acc), .txn_cnt (txn_cnt)
`endif
   );

   approx_mult_comp #(.N(8), .L(2)) u_cmp_main (.x_i(chk_x), .y_i(chk_y), .comp_o(cmp_main));

   for (genvar g = 0; g < 4; g++) begin : g_rnd
      approx_mult_pipe #(.N(8), .L(LS[g]), .ERR_ACC_W(8)) u_dut (
         .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (r_in_ready[g]),
         .x (x), .y (y), .approx_en (approx_en),
         .out_valid (r_out_valid[g]), .out_ready (out_ready), .z (r_z[g])
`ifdef APPROX_MULT_ERR_MON_EN
         , .err_last (r_err[g]), .err_acc (r_acc[g]), .txn_cnt (r_cnt[g])
`endif
      );
      approx_mult_comp #(.N(8), .L(LS[g])) u_cmp (.x_i(chk_x), .y_i(chk_y), .comp_o(cmp_r[g]));
   end

   task automatic check_eq(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic logic [15:0] model_z(input logic [7:0] xv, input logic [7:0] yv,
                                           input logic mv, input int unsigned lv,
                                           input logic [7:0] cv);
      logic [15:0] kept;
      if (!mv) return 16'(xv) * 16'(yv);
      kept = 16'(xv >> lv) * 16'(yv);
      return (kept << lv) + (16'(cv) << 8);
   endfunction

   function automatic logic signed [16:0] model_err(input logic [7:0] xv, input logic [7:0] yv,
                                                    input logic [15:0] zv);
      return $signed(17'(16'(xv) * 16'(yv))) - $signed(17'(zv));
   endfunction

   // Monitor: pushes accepted operands, pops and checks on output transfers, watches stalls.
   always @(negedge clk) begin
      sb_t e;
      logic [15:0] mz;
      if (rst) begin
         n_flush = n_flush + sb.size();
         sb.delete();
         run = 0;
         stall_prev = 1'b0;
`ifdef APPROX_MULT_ERR_MON_EN
         acc_m = 0; cnt_m = 0;
         for (int g = 0; g < 4; g++) begin acc_rm[g] = 0; cnt_rm[g] = 0; end
`endif
      end else begin
         if (stall_prev) begin
            check_eq("stall_hold_valid", out_valid, 1);
            check_eq("stall_hold_z", z, z_prev);
         end
         if (out_valid) run++;
         else begin
            if (run != 0) run_done = run;
            run = 0;
         end
         for (int g = 0; g < 4; g++) begin
            check_eq("hs_in_ready", r_in_ready[g], in_ready);
            check_eq("hs_out_valid", r_out_valid[g], out_valid);
         end
         if (out_valid && out_ready) begin
            check_eq("sb_avail", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_pop++;
               chk_x = e.x;
               chk_y = e.y;
               #1;
               mz = model_z(e.x, e.y, e.m, 2, cmp_main);
               check_eq("z_main", z, e.uc ? e.cz : mz);
`ifdef APPROX_MULT_ERR_MON_EN
               check_eq("err_main", err_last, e.uc ? e.ce : model_err(e.x, e.y, mz));
               check_eq("acc_main", err_acc, acc_m);
               check_eq("cnt_main", txn_cnt, cnt_m);
               acc_m = acc_m + ((err_last < 0) ? -longint'(err_last) : longint'(err_last));
               if (acc_m > 64'hFFFF_FFFF) acc_m = 64'hFFFF_FFFF;
               if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
`endif
               for (int g = 0; g < 4; g++) begin
                  mz = model_z(e.x, e.y, e.m, LS[g], cmp_r[g]);
                  check_eq($sformatf("z_l%0d", LS[g]), r_z[g], mz);
`ifdef APPROX_MULT_ERR_MON_EN
                  check_eq($sformatf("err_l%0d", LS[g]), r_err[g], model_err(e.x, e.y, mz));
                  check_eq($sformatf("acc_l%0d", LS[g]), r_acc[g], acc_rm[g]);
                  check_eq($sformatf("cnt_l%0d", LS[g]), r_cnt[g], cnt_rm[g]);
                  acc_rm[g] = acc_rm[g] + ((r_err[g] < 0) ? -longint'(r_err[g]) : longint'(r_err[g]));
                  if (acc_rm[g] > 255) acc_rm[g] = 255;
                  if (cnt_rm[g] < 255) cnt_rm[g]++;
`endif
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{x: x, y: y, m: approx_en, uc: cur_uc, cz: cur_cz, ce: cur_ce});
            n_push++;
         end
         stall_prev = out_valid && !out_ready;
         z_prev = z;
      end
   end

   task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic mv,
                       input logic uc, input logic [15:0] cz, input logic signed [16:0] ce);
      logic acc;
      int unsigned t;
      x = xv; y = yv; approx_en = mv;
      cur_uc = uc; cur_cz = cz; cur_ce = ce;
      in_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) check_eq("send_timeout", acc, 1);
      in_valid = 1'b0;
      cur_uc = 1'b0;
   endtask

   task automatic send_rand();
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, '0, '0);
   endtask

   task automatic wait_idle();
      int unsigned t;
      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n_acc, push0, cyc;
      logic acc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      x = '0; y = '0; approx_en = 1'b0;
      cur_uc = 1'b0; cur_cz = '0; cur_ce = '0;
      chk_x = '0; chk_y = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_in_ready", in_ready, 1);
      check_eq("post_rst_out_valid", out_valid, 0);
      check_eq("post_rst_z", z, 0);
`ifdef APPROX_MULT_ERR_MON_EN
      check_eq("post_rst_acc", err_acc, 0);
      check_eq("post_rst_cnt", txn_cnt, 0);
`endif
      @(posedge clk); #1;

      // Two-cycle latency on an idle pipe
      send(8'd255, 8'd255, 1'b1, 1'b1, 16'd64772, 17'sd253);
      @(negedge clk);
      check_eq("lat_edge1", out_valid, 0);
      @(negedge clk);
      check_eq("lat_edge2", out_valid, 1);
      @(posedge clk); #1;
      wait_idle();

      // Directed products and per-transaction mode switching
      send(8'd3, 8'd200, 1'b1, 1'b1, 16'd512, 17'sd88);
      send(8'd1, 8'd128, 1'b1, 1'b1, 16'd256, -17'sd128);
      send(8'd4, 8'd5, 1'b1, 1'b1, 16'd20, 17'sd0);
      send(8'd255, 8'd255, 1'b0, 1'b1, 16'd65025, 17'sd0);
      send(8'd255, 8'd255, 1'b1, 1'b1, 16'd64772, 17'sd253);
      wait_idle();

      // Six back-to-back operands
      repeat (6) send_rand();
      wait_idle();
      check_eq("stream_run", run_done, 6);

      // Backpressure: in_ready drops after two accepts
      out_ready = 1'b0;
      n_acc = 0;
      x = 8'($urandom); y = 8'($urandom); approx_en = 1'($urandom);
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            x = 8'($urandom); y = 8'($urandom); approx_en = 1'($urandom);
         end
      end
      @(negedge clk);
      check_eq("stall_accepts", n_acc, 2);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset with two transactions in flight
      out_ready = 1'b0;
      send_rand();
      send_rand();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_z", z, 0);
`ifdef APPROX_MULT_ERR_MON_EN
      check_eq("midrst_acc", err_acc, 0);
      check_eq("midrst_cnt", txn_cnt, 0);
`endif
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Random traffic with random backpressure
      push0 = n_push;
      cyc = 0;
      while (n_push - push0 < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         x = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
         y = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
         approx_en = 1'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      check_eq("random_count", n_push - push0 >= 10000, 1);
      check_eq("push_pop_balance", n_pop + n_flush, n_push);
`ifdef APPROX_MULT_ERR_MON_EN
      check_eq("acc_sat_l7", r_acc[3], 255);
      check_eq("cnt_sat_l0", r_cnt[0], 255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
